seq_multiplier_32bit: RTL and testbench

Iterative shift-and-add multiplier for the RISC-V M-extension ops MUL, MULH, MULHSU and MULHU. It sits directly upstream of full_adder_32bit and drives that adder's a/b/c_in once per cycle. It consumes the sum and c_out to build a 64-bit product over 32 cycles. It is launched by the execute stage with a start/done handshake, and returns the selected 32-bit half.

---
 rtl/seq_multiplier_32bit.sv | 153 +++++++++++++++
 tb/tb_seq_multiplier_32bit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_32bit.sv
// rtl/seq_multiplier_32bit.sv - iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU
// Optional SEQ_MUL_EARLY_EXIT_EN: finish CALC once the remaining multiplier bits are zero.

module full_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module seq_multiplier_32bit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   acc_hi_q;
    logic [XLEN-1:0]   mplier_q;
    logic [CNT_W-1:0]  count_q;
    logic              neg_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   add_b;
    logic [XLEN-1:0]   add_sum;
    logic              add_cout;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_abs_d, b_abs_d;
    logic [2*XLEN:0]   step_full;
    logic [CNT_W:0]    shamt;
    logic [2*XLEN-1:0] step_d;
    logic              last_step;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_d;

    assign add_b = mplier_q[0] ? mcand_q : '0;

    full_adder_32bit u_adder (
        .a     (acc_hi_q),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        a_neg   = (op == OP_MULH || op == OP_MULHSU) && a[XLEN-1];
        b_neg   = (op == OP_MULH) && b[XLEN-1];
        a_abs_d = a_neg ? (~a + 1'b1) : a;
        b_abs_d = b_neg ? (~b + 1'b1) : b;

        step_full = {add_cout, add_sum, mplier_q};
`ifdef SEQ_MUL_EARLY_EXIT_EN
        // No set bits left above bit 0: one wide shift covers every remaining step.
        if (mplier_q[XLEN-1:1] == '0) begin
            shamt     = (CNT_W+1)'(XLEN) - {1'b0, count_q};
            last_step = 1'b1;
        end else begin
            shamt     = (CNT_W+1)'(1);
            last_step = (count_q == CNT_W'(XLEN-1));
        end
`else
        shamt     = (CNT_W+1)'(1);
        last_step = (count_q == CNT_W'(XLEN-1));
`endif
        step_d = (2*XLEN)'(step_full >> shamt);

        prod   = {acc_hi_q, mplier_q};
        prod_d = neg_q ? (~prod + 1'b1) : prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        mcand_q  <= a_abs_d;
                        mplier_q <= b_abs_d;
                        acc_hi_q <= '0;
                        count_q  <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi_q <= step_d[2*XLEN-1:XLEN];
                    mplier_q <= step_d[XLEN-1:0];
                    count_q  <= count_q + 1'b1;
                    if (last_step) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= (op_q == OP_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
                    done_q   <= 1'b1;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// tb/tb_seq_multiplier_32bit.sv - directed self-checking bench for seq_multiplier_32bit

module tb_seq_multiplier_32bit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int k;
    int seen;

    seq_multiplier_32bit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge E.
    task automatic launch(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // k0 = number of edges already elapsed since E.
    task automatic wait_done(input int k0, input int lat, input logic [31:0] res, input string tag);
        k = k0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_ready"}, {31'b0, ready}, 32'd0);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_res"}, result, res);
        check({tag, "_idle"}, {30'b0, ready, busy}, 32'd2);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7*6 with full handshake timing
        launch(2'b00, 32'd7, 32'd6);
        wait_done(0, 33, 32'h0000002A, "mul7x6");
        @(negedge clk);
        check("mul7x6_done_drop", {31'b0, done}, 32'd0);
        check("mul7x6_hold", result, 32'h0000002A);

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, 33, 32'h00000000, "mulh_m1m1");
        @(negedge clk);
        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, 33, 32'h00000001, "mul_m1m1");
        @(negedge clk);
        launch(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, 33, 32'hFFFFFFFE, "mulhu_max");
        @(negedge clk);
        launch(2'b10, 32'hFFFFFFFE, 32'd3);
        wait_done(0, 33, 32'hFFFFFFFF, "mulhsu_m2x3");
        @(negedge clk);
        launch(2'b00, 32'hFFFFFFFE, 32'd3);
        wait_done(0, 33, 32'hFFFFFFFA, "mul_m2x3");
        @(negedge clk);

        // MULH min*min, then back-to-back start in the done cycle
        launch(2'b01, 32'h80000000, 32'h80000000);
        wait_done(0, 33, 32'h40000000, "mulh_min");
        launch(2'b00, 32'd3, 32'd5);
        wait_done(0, 33, 32'h0000000F, "b2b_mul3x5");
        @(negedge clk);

        // start pulse while busy must be ignored
        launch(2'b11, 32'h00010000, 32'h00010000);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 33, 32'h00000001, "ignore_start");
        @(negedge clk);

        // asynchronous reset mid-CALC
        launch(2'b00, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_idle", {30'b0, ready, busy}, 32'd2);

`ifdef SEQ_MUL_EARLY_EXIT_EN
        launch(2'b00, 32'd9, 32'd1);
        wait_done(0, 2, 32'd9, "ee_mul9x1");
        @(negedge clk);
        launch(2'b00, 32'd9, 32'd0);
        wait_done(0, 2, 32'd0, "ee_mul9x0");
        @(negedge clk);
`else
        launch(2'b00, 32'd9, 32'd1);
        wait_done(0, 33, 32'd9, "mul9x1");
        @(negedge clk);
        launch(2'b00, 32'd9, 32'd0);
        wait_done(0, 33, 32'd0, "mul9x0");
        @(negedge clk);
`endif
        launch(2'b11, 32'd3, 32'h80000000);
        wait_done(0, 33, 32'h00000001, "mulhu_3xmsb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
